// File: rtl/uart_rx_line_buffer_pkg.sv
// Shared constants for the UART receive line buffer: register map,
// STATUS/CTRL bit positions and reset values.
package uart_rx_line_buffer_pkg;

  typedef enum logic [2:0] {
    ADR_DATA   = 3'd0,
    ADR_STATUS = 3'd1,
    ADR_LEVEL  = 3'd2,
    ADR_CTRL   = 3'd3,
    ADR_THRESH = 3'd4
  } reg_adr_e;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_LINE  = 3;
  localparam int unsigned ST_OVF   = 4;

  // CTRL bit positions; only the three enables are stored
  localparam int unsigned CTRL_LINE_IE = 0;
  localparam int unsigned CTRL_LVL_IE  = 1;
  localparam int unsigned CTRL_OVF_IE  = 2;
  localparam int unsigned CTRL_FLUSH   = 7;

  localparam logic [7:0] THRESH_RST = 8'h08;

endpackage

// File: rtl/uart_rx_line_buffer_if.sv
// 8-bit Wishbone classic bus between the CPU-side master and the buffer.
interface uart_rx_line_buffer_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/uart_rx_line_buffer_fifo.sv
// Byte FIFO with combinational head, same-cycle push+pop and synchronous flush.
// The caller guarantees push only when not full (or popping) and pop only
// when not empty.
module sync_byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [7:0]            i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [7:0]            o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == DEPTH[DEPTH_LOG2:0]);
  assign o_empty = (r_count == '0);

  // Storage write; no reset needed since count gates validity
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_line_buffer.sv
// UART receive line buffer: byte FIFO behind the uart_transceiver rx strobe,
// line counting on a terminator byte, 8-bit Wishbone register slave and one
// registered level interrupt.
module uart_rx_line_buffer
  import uart_rx_line_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  LINE_CHAR  = 8'h0A
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_done_i,
  uart_rx_line_buffer_if.slave    wb,
  output logic                    irq_o
);

  logic                r_ack;
  logic                r_err;
  logic [7:0]          r_dat_o;
  logic                r_irq;
  logic                r_ovf;
  logic                r_flush;
  logic [2:0]          r_ctrl;
  logic [7:0]          r_thresh;
  logic [DEPTH_LOG2:0] r_lines;

  logic                w_req;
  logic                w_adr_ok;
  logic                w_rd;
  logic                w_wr;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic                w_ctrl_wr;
  logic                w_thresh_wr;
  logic                w_flush_req;
  logic                w_line_in;
  logic                w_line_out;
  logic                w_lvl_hit;
  logic                w_irq_next;
  logic [7:0]          w_head;
  logic [7:0]          w_rdata;
  logic [7:0]          w_count_ext;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;

  // Bus decode: a request is only seen while no response is outstanding
  assign w_req       = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
  assign w_adr_ok    = (wb.wb_adr_i <= ADR_THRESH);
  assign w_rd        = w_req & ~wb.wb_we_i & w_adr_ok;
  assign w_wr        = w_req &  wb.wb_we_i & w_adr_ok;
  assign w_pop       = w_rd & (wb.wb_adr_i == ADR_DATA) & ~w_empty;
  assign w_ovf_clr   = w_wr & (wb.wb_adr_i == ADR_STATUS) & wb.wb_dat_i[ST_OVF];
  assign w_ctrl_wr   = w_wr & (wb.wb_adr_i == ADR_CTRL);
  assign w_thresh_wr = w_wr & (wb.wb_adr_i == ADR_THRESH);
  assign w_flush_req = w_ctrl_wr & wb.wb_dat_i[CTRL_FLUSH];

  // Receive side: a pop in the same cycle frees the slot for the new byte;
  // bytes arriving while the flush is applied are dropped without ovf
  assign w_push      = rx_done_i & ~r_flush & (~w_full | w_pop);
  assign w_ovf_set   = rx_done_i & ~r_flush &  w_full & ~w_pop;
  assign w_line_in   = w_push & (rx_data_i == LINE_CHAR);
  assign w_line_out  = w_pop  & (w_head == LINE_CHAR);

  assign w_count_ext = {{(7 - DEPTH_LOG2){1'b0}}, w_count};
  assign w_lvl_hit   = (w_count_ext >= r_thresh) && (r_thresh != '0);
  assign w_irq_next  = (r_ctrl[CTRL_LINE_IE] & (r_lines != '0)) |
                       (r_ctrl[CTRL_LVL_IE]  & w_lvl_hit) |
                       (r_ctrl[CTRL_OVF_IE]  & r_ovf);

  sync_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_push  (w_push),
    .i_data  (rx_data_i),
    .i_pop   (w_pop),
    .i_flush (r_flush),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Read-data mux, sampled in the request cycle (before any pop)
  always_comb begin
    w_rdata = '0;
    case (wb.wb_adr_i)
      ADR_DATA:   w_rdata = w_empty ? '0 : w_head;
      ADR_STATUS: begin
        w_rdata[ST_OVF]   = r_ovf;
        w_rdata[ST_LINE]  = (r_lines != '0);
        w_rdata[ST_FULL]  = w_full;
        w_rdata[ST_EMPTY] = w_empty;
      end
      ADR_LEVEL:  w_rdata[DEPTH_LOG2:0] = w_count;
      ADR_CTRL:   w_rdata[2:0] = r_ctrl;
      ADR_THRESH: w_rdata = r_thresh;
      default:    w_rdata = '0;
    endcase
  end

  // Registered single-cycle ack/err with read data valid only alongside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack   <= w_req &  w_adr_ok;
      r_err   <= w_req & ~w_adr_ok;
      r_dat_o <= w_rd ? w_rdata : '0;
    end
  end

  // Control registers; flush is applied one cycle after its write request
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl   <= '0;
      r_thresh <= THRESH_RST;
      r_flush  <= 1'b0;
    end else begin
      r_flush <= w_flush_req;
      if (w_ctrl_wr)   r_ctrl   <= wb.wb_dat_i[2:0];
      if (w_thresh_wr) r_thresh <= wb.wb_dat_i;
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)     r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // Count of terminator bytes currently held in the FIFO
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_lines <= '0;
    end else if (r_flush) begin
      r_lines <= '0;
    end else begin
      case ({w_line_in, w_line_out})
        2'b10:   r_lines <= r_lines + (DEPTH_LOG2+1)'(1);
        2'b01:   r_lines <= r_lines - (DEPTH_LOG2+1)'(1);
        default: r_lines <= r_lines;
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_irq <= 1'b0;
    else            r_irq <= w_irq_next;
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat_o;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Self-checking bench for uart_rx_line_buffer against a queue-based model.
module tb_uart_rx_line_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       irq;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [2:0] m_ctrl = '0;
  logic [7:0] m_thresh = 8'h08;

  uart_rx_line_buffer_if wb();

  uart_rx_line_buffer #(
    .DEPTH_LOG2 (4),
    .LINE_CHAR  (8'h0A)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .rx_data_i (rx_data),
    .rx_done_i (rx_done),
    .wb        (wb),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic int m_lines();
    int n = 0;
    foreach (q[i]) if (q[i] == 8'h0A) n++;
    return n;
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[0] && m_lines() != 0) ||
           (m_ctrl[1] && q.size() >= int'(m_thresh) && m_thresh != 0) ||
           (m_ctrl[2] && m_ovf);
  endfunction

  function automatic logic [7:0] m_status();
    logic [7:0] s = '0;
    s[4] = m_ovf;
    s[3] = (m_lines() != 0);
    s[2] = (q.size() == 16);
    s[1] = (q.size() == 0);
    return s;
  endfunction

  function automatic logic [7:0] m_pop();
    if (q.size() == 0) return 8'h00;
    return q.pop_front();
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovf = 1'b0;
    m_ctrl = '0;
    m_thresh = 8'h08;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    if (q.size() < 16) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic ack, output logic err);
    @(negedge clk);
    wb.wb_adr_i = adr;
    wb.wb_dat_i = wd;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(negedge clk);
    rd  = wb.wb_dat_o;
    ack = wb.wb_ack_o;
    err = wb.wb_err_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic a, e;
    logic [2:0] ta [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [7:0] te [4] = '{8'h00, 8'h02, 8'h00, 8'h08};
    rst_n = 1'b0;
    idle(3);
    total++; if (wb.wb_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", wb.wb_ack_o); end
    total++; if (wb.wb_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", wb.wb_err_o); end
    total++; if (wb.wb_dat_o !== 8'h00) begin bad++; $display("FAIL rst_dat got=%h exp=00", wb.wb_dat_o); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    m_reset();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, ta[i], 8'h00, d, a, e);
      total++; if (d !== te[i] || a !== 1'b1) begin bad++; $display("FAIL rst_reg%0d got=%h ack=%b exp=%h", ta[i], d, a, te[i]); end
    end
  endtask

  task automatic test_line();
    logic [7:0] d, exp; logic a, e;
    bus(1'b1, 3'd3, 8'h01, d, a, e); m_ctrl = 3'b001;
    push(8'h48); push(8'h69); push(8'h0A);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL line_irq_early got=%b exp=0", irq); end
    idle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL line_irq_rise got=%b exp=1", irq); end
    bus(1'b0, 3'd2, 8'h00, d, a, e);
    total++; if (d !== 8'(q.size())) begin bad++; $display("FAIL line_level got=%h exp=%h", d, 8'(q.size())); end
    bus(1'b0, 3'd1, 8'h00, d, a, e);
    total++; if (d !== m_status()) begin bad++; $display("FAIL line_status got=%h exp=%h", d, m_status()); end
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 3'd0, 8'h00, d, a, e);
      exp = m_pop();
      total++; if (d !== exp || a !== 1'b1) begin bad++; $display("FAIL line_rd%0d got=%h ack=%b exp=%h", i, d, a, exp); end
    end
    idle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL line_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic a, e;
    bus(1'b1, 3'd3, 8'h00, d, a, e); m_ctrl = '0;
    for (int i = 0; i < 17; i++) push(8'(i));
    bus(1'b0, 3'd1, 8'h00, d, a, e);
    total++; if (d !== m_status()) begin bad++; $display("FAIL ovf_status got=%h exp=%h", d, m_status()); end
    bus(1'b1, 3'd1, 8'h10, d, a, e); m_ovf = 1'b0;
    bus(1'b0, 3'd1, 8'h00, d, a, e);
    total++; if (d !== m_status()) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", d, m_status()); end
  endtask

  task automatic test_simul();
    logic [7:0] d, exp; logic a, e;
    @(negedge clk);
    wb.wb_adr_i = 3'd0; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    rx_data = 8'h55; rx_done = 1'b1;
    @(negedge clk);
    d = wb.wb_dat_o; a = wb.wb_ack_o;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; rx_done = 1'b0;
    exp = m_pop();
    q.push_back(8'h55);
    total++; if (d !== exp || a !== 1'b1) begin bad++; $display("FAIL simul_rd got=%h ack=%b exp=%h", d, a, exp); end
    bus(1'b0, 3'd1, 8'h00, d, a, e);
    total++; if (d !== m_status()) begin bad++; $display("FAIL simul_status got=%h exp=%h", d, m_status()); end
    bus(1'b0, 3'd2, 8'h00, d, a, e);
    total++; if (d !== 8'(q.size())) begin bad++; $display("FAIL simul_level got=%h exp=%h", d, 8'(q.size())); end
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 3'd0, 8'h00, d, a, e);
      exp = m_pop();
      total++; if (d !== exp) begin bad++; $display("FAIL simul_drain%0d got=%h exp=%h", i, d, exp); end
    end
  endtask

  task automatic test_empty();
    logic [7:0] d; logic a, e;
    bus(1'b0, 3'd0, 8'h00, d, a, e);
    total++; if (d !== 8'h00 || a !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL empty_rd got=%h ack=%b err=%b exp=00/1/0", d, a, e); end
    bus(1'b0, 3'd2, 8'h00, d, a, e);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL empty_level got=%h exp=00", d); end
    bus(1'b0, 3'd6, 8'h00, d, a, e);
    total++; if (e !== 1'b1 || a !== 1'b0 || d !== 8'h00) begin bad++; $display("FAIL err_adr6 got err=%b ack=%b dat=%h exp=1/0/00", e, a, d); end
    bus(1'b1, 3'd5, 8'hFF, d, a, e);
    total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL err_adr5 got err=%b ack=%b exp=1/0", e, a); end
    bus(1'b0, 3'd4, 8'h00, d, a, e);
    total++; if (d !== m_thresh) begin bad++; $display("FAIL err_noeffect got=%h exp=%h", d, m_thresh); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic       pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    push(8'hA1); push(8'h5C);
    @(negedge clk);
    wb.wb_adr_i = 3'd0; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = pat[k] ? m_pop() : 8'h00;
      total++; if (wb.wb_ack_o !== pat[k] || wb.wb_dat_o !== exp) begin
        bad++; $display("FAIL b2b_cyc%0d got ack=%b dat=%h exp ack=%b dat=%h", k, wb.wb_ack_o, wb.wb_dat_o, pat[k], exp);
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] d; logic a, e;
    bus(1'b1, 3'd4, 8'h04, d, a, e); m_thresh = 8'h04;
    bus(1'b1, 3'd3, 8'h02, d, a, e); m_ctrl = 3'b010;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    idle(1);
    total++; if (irq !== m_irq()) begin bad++; $display("FAIL thr_below got=%b exp=%b", irq, m_irq()); end
    push(8'($urandom_range(0, 255)));
    idle(1);
    total++; if (irq !== m_irq()) begin bad++; $display("FAIL thr_hit got=%b exp=%b", irq, m_irq()); end
    for (int i = 0; i < 13; i++) push(8'($urandom_range(0, 255)));
    bus(1'b1, 3'd3, 8'h82, d, a, e); m_ctrl = 3'b010; q.delete();
    idle(2);
    total++; if (irq !== m_irq()) begin bad++; $display("FAIL flush_irq got=%b exp=%b", irq, m_irq()); end
    bus(1'b0, 3'd2, 8'h00, d, a, e);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL flush_level got=%h exp=00", d); end
    bus(1'b0, 3'd1, 8'h00, d, a, e);
    total++; if (d !== m_status()) begin bad++; $display("FAIL flush_status got=%h exp=%h", d, m_status()); end
    bus(1'b0, 3'd3, 8'h00, d, a, e);
    total++; if (d !== {5'b0, m_ctrl}) begin bad++; $display("FAIL flush_ctrl got=%h exp=%h", d, {5'b0, m_ctrl}); end
    bus(1'b1, 3'd1, 8'h10, d, a, e); m_ovf = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d, exp; logic a, e;
    int op;
    m_thresh = 8'($urandom_range(0, 18));
    bus(1'b1, 3'd4, m_thresh, d, a, e);
    m_ctrl = 3'($urandom_range(0, 7));
    bus(1'b1, 3'd3, {5'b0, m_ctrl}, d, a, e);
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 10);
      if (op <= 4) begin
        push(($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255)));
      end else if (op <= 7) begin
        bus(1'b0, 3'd0, 8'h00, d, a, e);
        exp = m_pop();
        total++; if (d !== exp) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, d, exp); end
      end else if (op == 8) begin
        bus(1'b0, 3'd1, 8'h00, d, a, e);
        total++; if (d !== m_status()) begin bad++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, m_status()); end
      end else if (op == 9) begin
        bus(1'b0, 3'd2, 8'h00, d, a, e);
        total++; if (d !== 8'(q.size())) begin bad++; $display("FAIL rnd_level it=%0d got=%h exp=%h", it, d, 8'(q.size())); end
      end else begin
        bus(1'b1, 3'd1, 8'h10, d, a, e); m_ovf = 1'b0;
      end
      idle(1);
      total++; if (irq !== m_irq()) begin bad++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, irq, m_irq()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic a, e;
    logic [7:0] bytes [5] = '{8'h31, 8'h32, 8'h0A, 8'h33, 8'h34};
    while (q.size() != 0) begin bus(1'b0, 3'd0, 8'h00, d, a, e); void'(m_pop()); end
    bus(1'b1, 3'd3, 8'h01, d, a, e); m_ctrl = 3'b001;
    foreach (bytes[i]) push(bytes[i]);
    idle(1);
    total++; if (irq !== m_irq()) begin bad++; $display("FAIL mid_irq_pre got=%b exp=%b", irq, m_irq()); end
    @(negedge clk);
    wb.wb_adr_i = 3'd2; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    @(posedge clk); #2;
    total++; if (wb.wb_ack_o !== 1'b1) begin bad++; $display("FAIL mid_ack_pre got=%b exp=1", wb.wb_ack_o); end
    rst_n = 1'b0;
    #1;
    total++; if (wb.wb_ack_o !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL mid_async got ack=%b irq=%b exp=0/0", wb.wb_ack_o, irq); end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    bus(1'b0, 3'd2, 8'h00, d, a, e);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_level got=%h exp=00", d); end
    bus(1'b0, 3'd4, 8'h00, d, a, e);
    total++; if (d !== m_thresh) begin bad++; $display("FAIL mid_thresh got=%h exp=%h", d, m_thresh); end
  endtask

  initial begin
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_we_i  = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    test_reset();
    test_line();
    test_overflow();
    test_simul();
    test_empty();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
